// File: rtl/act_lut_interp_pipe.sv
// Piecewise-linear activation LUT with runtime-loadable entries; 3-stage pipe, 3-cycle latency.
// Valid/ready throughout: a stall at out_ready ripples back to in_ready combinationally, nothing dropped.
module act_lut_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  input  logic              lut_we,
  input  logic [ADDR_W-1:0] lut_waddr,
  input  logic [DATA_W-1:0] lut_wdata,
  output logic              busy
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PW     = DATA_W + FRAC_W + 2;
  localparam int DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'(DEPTH/2 - 1);

  logic signed [DATA_W-1:0] lut [DEPTH];

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  logic [ADDR_W-1:0]        idx, idx_n;
  logic signed [DATA_W-1:0] rd_base, rd_nxt;

  logic signed [DATA_W-1:0] base1, nxt1;
  logic [FRAC_W-1:0]        rem1;
  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_x, rem_x, prod;

  logic signed [DATA_W-1:0] base2;
  logic signed [PW-1:0]     prod2;
  logic signed [DATA_W-1:0] a_c;

  assign adv3      = !v3 | out_ready;
  assign adv2      = !v2 | adv3;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  // The most-positive segment has no right neighbour: extrapolate flat instead of wrapping to the negative end.
  assign idx     = in_z[DATA_W-1:FRAC_W];
  assign idx_n   = idx + ADDR_W'(1);
  assign rd_base = lut[idx];
  assign rd_nxt  = (idx == TOP_IDX) ? rd_base : lut[idx_n];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      base1 <= '0;
      nxt1  <= '0;
      rem1  <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        base1 <= rd_base;
        nxt1  <= rd_nxt;
        rem1  <= in_z[FRAC_W-1:0];
      end
    end
  end

  assign diff   = {nxt1[DATA_W-1], nxt1} - {base1[DATA_W-1], base1};
  assign diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
  assign rem_x  = {{(PW-FRAC_W){1'b0}}, rem1};
  assign prod   = diff_x * rem_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2    <= 1'b0;
      base2 <= '0;
      prod2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        base2 <= base1;
        prod2 <= prod;
      end
    end
  end

  // Result sits between base and nxt, so wrapping low-bit addition is exact.
  assign a_c = base2 + DATA_W'(prod2 >>> FRAC_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3    <= 1'b0;
      out_a <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) out_a <= a_c;
    end
  end

endmodule

// File: tb/tb_act_lut_interp_pipe.sv
// Scoreboard bench for act_lut_interp_pipe: integer reference model, scenario tasks run in sequence.
module tb_act_lut_interp_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_z;
  logic       out_valid, out_ready;
  logic [7:0] out_a;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [7:0] lut_wdata;
  logic       busy;

  act_lut_interp_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mlut [16];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         acc_cyc_q [$];
  int         got_cyc_q [$];
  int         cyc = 0;
  int         stall_bad = 0;
  bit         saw_rdy_low = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_a = 8'h00;
  int         rdy_mode = 0;
  int         ph = 0;

  function automatic logic [7:0] model(input logic [7:0] z);
    int idx, rem, b, n, p;
    idx = int'(z[7:4]);
    rem = int'(z[3:0]);
    b = int'($signed(mlut[idx]));
    n = (idx == 7) ? b : int'($signed(mlut[(idx + 1) % 16]));
    p = (n - b) * rem;
    b = b + (p >>> 4);
    return b[7:0];
  endfunction

  // Monitor: push expectations at accept, capture outputs at emit, track stall stability.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) mlut[i] = 8'h00;
      prev_stall = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_z));
        acc_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_a);
        got_cyc_q.push_back(cyc);
      end
      if (prev_stall && out_a !== prev_a) stall_bad++;
      if (busy && !in_ready) saw_rdy_low = 1;
      prev_stall = out_valid && !out_ready;
      prev_a = out_a;
      if (lut_we) mlut[lut_waddr] = lut_wdata;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required earlier", $time);
    $fatal(1);
  end

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); got_cyc_q.delete();
  endtask

  task automatic write_lut(input logic [3:0] a, input logic [7:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    @(posedge clk); #1;
    lut_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] z);
    bit acc;
    in_valid = 1'b1; in_z = z;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, output bit ok);
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= n && !busy) break;
      @(posedge clk); #1;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_chk++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL reset_out_a got %h want 00", out_a); end
  endtask

  task automatic test_pos_slope();
    bit ok; logic [7:0] e, g; int lat;
    clear_q(); rdy_mode = 0;
    write_lut(4'd2, 8'h20); write_lut(4'd3, 8'h40);
    send(8'h28);
    drain(1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL pos_drain got %0d outputs want 1", got_q.size()); end
    if (ok) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      lat = got_cyc_q[0] - acc_cyc_q[0];
      n_chk++; if (g !== 8'h30) begin n_fail++; $display("FAIL pos_value got %h want 30", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL pos_model got %h want %h", g, e); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL pos_latency got %0d want 3", lat); end
    end
  endtask

  task automatic test_neg_slope();
    bit ok; logic [7:0] e, g;
    clear_q(); rdy_mode = 0;
    write_lut(4'd5, 8'h10); write_lut(4'd6, 8'h00);
    send(8'h53);
    drain(1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL neg_drain got %0d outputs want 1", got_q.size()); end
    if (ok) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== 8'h0D) begin n_fail++; $display("FAIL neg_value got %h want 0d", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL neg_model got %h want %h", g, e); end
    end
  endtask

  task automatic test_boundaries();
    bit ok; logic [7:0] e, g;
    clear_q(); rdy_mode = 0;
    write_lut(4'd7, 8'h7F);
    send(8'h7F);
    write_lut(4'd15, 8'hF8); write_lut(4'd0, 8'h00);
    send(8'hF8);
    drain(2, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bound_drain got %0d outputs want 2", got_q.size()); end
    if (ok) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== 8'h7F) begin n_fail++; $display("FAIL bound_flat got %h want 7f", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL bound_flat_model got %h want %h", g, e); end
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== 8'hFC) begin n_fail++; $display("FAIL bound_wrap got %h want fc", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL bound_wrap_model got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [7:0] e, g;
    clear_q(); rdy_mode = 0;
    write_lut(4'd1, 8'hE0); write_lut(4'd4, 8'h55); write_lut(4'd9, 8'h90);
    for (int k = 0; k < 8; k++) send(8'(k * 37 + 5));
    drain(8, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_drain got %0d outputs want 8", got_q.size()); end
    if (ok) begin
      n_chk++; if (acc_cyc_q[7] - acc_cyc_q[0] !== 7) begin n_fail++; $display("FAIL b2b_accept_span got %0d want 7", acc_cyc_q[7] - acc_cyc_q[0]); end
      n_chk++; if (got_cyc_q[7] - got_cyc_q[0] !== 7) begin n_fail++; $display("FAIL b2b_emit_span got %0d want 7", got_cyc_q[7] - got_cyc_q[0]); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_chk++; if (g !== e) begin n_fail++; $display("FAIL b2b_value[%0d] got %h want %h", k, g, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic [7:0] e, g;
    clear_q(); stall_bad = 0; saw_rdy_low = 0;
    ph = 0; rdy_mode = 1;
    for (int k = 0; k < 10; k++) send(8'(k * 16));
    drain(10, ok);
    repeat (6) begin @(posedge clk); #1; end
    rdy_mode = 0;
    n_chk++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL bp_count got %0d want 10", got_q.size()); end
    n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
    n_chk++; if (saw_rdy_low !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_drop got %b want 1", saw_rdy_low); end
    if (ok && exp_q.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_chk++; if (g !== e) begin n_fail++; $display("FAIL bp_value[%0d] got %h want %h", k, g, e); end
      end
    end
  endtask

  task automatic test_write_hazard();
    bit ok; logic [7:0] e, g;
    clear_q(); rdy_mode = 0;
    write_lut(4'd2, 8'h20);
    lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 8'h40;
    send(8'h20);
    lut_we = 1'b0;
    send(8'h20);
    drain(2, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL haz_drain got %0d outputs want 2", got_q.size()); end
    if (ok) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== 8'h20) begin n_fail++; $display("FAIL haz_old got %h want 20", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL haz_old_model got %h want %h", g, e); end
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++; if (g !== 8'h40) begin n_fail++; $display("FAIL haz_new got %h want 40", g); end
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL haz_new_model got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [7:0] g;
    clear_q(); rdy_mode = 2;
    @(posedge clk); #1;
    send(8'h28); send(8'h53); send(8'hF8);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_chk++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL rmid_out_a got %h want 00", out_a); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    rdy_mode = 0;
    clear_q();
    repeat (10) begin @(posedge clk); #1; end
    n_chk++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rmid_stale got %0d outputs want 0", got_q.size()); end
    send(8'h20); send(8'h70); send(8'hF0);
    drain(3, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_drain got %0d outputs want 3", got_q.size()); end
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        g = got_q.pop_front();
        n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL rmid_lut_cleared[%0d] got %h want 00", k, g); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_z = 8'h00;
    lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 8'h00;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_pos_slope();
    test_neg_slope();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_write_hazard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_lut_interp_pipe.md
# act_lut_interp_pipe

Pipelined, parametrised activation-function unit for the neuron datapath. It maps a signed fixed-point pre-activation `z` to an activation `a` by piecewise-linear interpolation between entries of a LUT that software can load at runtime. Three register stages sit behind a valid/ready handshake, so the unit can sit directly between the MAC accumulator stage and the layer output buffer and absorb backpressure.

## Interface
- `DATA_W`, 8: width of `z`, `a` and the LUT entries; all are signed two's complement.
- `ADDR_W`, 4: number of `z` MSBs used as the segment index. The LUT has 2^ADDR_W entries.
- `FRAC_W`, derived as DATA_W-ADDR_W: number of `z` LSBs used as the interpolation fraction. ADDR_W must be at least 2, and FRAC_W must be at least 1.
- `clk`  in  1  sole clock; every register samples on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_z` is valid.
- `in_ready`  out  1  the unit accepts `in_z` this cycle.
- `in_z`  in  DATA_W  pre-activation value.
- `out_valid`  out  1  `out_a` is valid.
- `out_ready`  in  1  the consumer accepts `out_a`.
- `out_a`  out  DATA_W  activation result.
- `lut_we`  in  1  LUT write strobe.
- `lut_waddr`  in  ADDR_W  LUT write index.
- `lut_wdata`  in  DATA_W  LUT write data.
- `busy`  out  1  OR of the three stage-valid flags.

## Operation
- **Segment index.** `idx = z[DATA_W-1 : FRAC_W]`, taken as raw bits. Negative `z` therefore indexes the upper half of the LUT.
- **Fraction.** `rem = z[FRAC_W-1:0]`, zero-extended. The implicit segment step is 2^FRAC_W.
- **Base entry.** `base = lut[idx]`.
- **Next entry.** `nxt = lut[(idx+1) mod 2^ADDR_W]`. Exception: when `idx == 2^(ADDR_W-1)-1` (the most-positive segment), `nxt = base`, giving flat extrapolation. The wrap from the most-negative segment back toward zero (idx = 2^ADDR_W-1 to 0) is legal and interpolates normally.
- **Result.** `a = base + ((nxt - base) * rem) >>> FRAC_W`.
  - The difference is DATA_W+1 bits and the product is DATA_W+FRAC_W+2 bits.
  - The shift is arithmetic (floor).
  - The result always lies between `base` and `nxt`, so it never overflows; no saturation logic is present.
- **Stages.**
  - S1 captures `z`, reads `base` and `nxt`, and registers `base`, `nxt` and `rem`.
  - S2 registers `base` and the product.
  - S3 registers `a`.
- **Stage advance.** Each stage holds a valid flag and advances when it is empty or when its downstream stage advances. `in_ready = !v1 | adv1`, and `out_valid = v3`.
- **LUT writes.**
  - A write completes at the clock edge and may occur at any time, including while the pipeline is busy.
  - A sample entering S1 in the same cycle as a write to an entry it reads uses the old value. Samples captured later use the new value.
  - Writes never stall the handshake.

## Timing
- **Reset (`rst` = 0).** All stage-valid flags, `out_valid`, `busy`, every LUT entry and `out_a` go to 0 immediately. `in_ready` then reads 1.
- **Reset mid-operation.** In-flight samples are discarded, not flushed. No `out_valid` pulse occurs for them after `rst` releases.
- **Latency.** 3 cycles from the accept edge (`in_valid & in_ready`) to the first cycle of `out_valid`.
- **Throughput.** 1 sample per cycle while `out_ready` is held at 1.
- **Backpressure.**
  - While `out_valid & !out_ready`, `out_a` is held stable.
  - Once S1–S3 are all full, `in_ready` drops in the same cycle `out_ready` is low (combinational path).
  - No sample is dropped or duplicated.
- **Simultaneous accept and emit.** A full pipeline with `out_ready` = 1 accepts a new input in the same cycle it emits.
- **Idle output.** `out_a` holds its last value when `out_valid` = 0.

## Test plan
- **Positive slope.** Load lut[2]=0x20 and lut[3]=0x40, then send z=0x28 -> `out_a` = 0x30, with `out_valid` exactly 3 cycles after accept.
- **Negative slope and floor rounding.** Load lut[5]=0x10 and lut[6]=0x00, then send z=0x53 -> 0x0D (difference -16×3 = -48, shifted to -3).
- **Boundaries.**
  - Load lut[7]=0x7F and send z=0x7F -> 0x7F (flat segment).
  - Load lut[15]=0xF8 and lut[0]=0x00, then send z=0xF8 -> 0xFC (wrap segment).
- **Backpressure.** Stream 10 inputs z=0x00..0x90 with `out_ready` toggling 1,0,0,1… -> exactly 10 outputs, in order, each matching the model, and `out_a` stable during every stall.
- **Write hazard.** Write lut[2]=0x40 in the same cycle z=0x20 is accepted -> old value of lut[2]. The next sample z=0x20 -> 0x40.
- **Reset mid-stream.** Assert `rst` while `busy` = 1 -> `out_valid`, `busy` and `out_a` go to 0 immediately. After release, no stale output appears and a read of any LUT entry returns 0.
